axis_bist_src: RTL and testbench

- AXI4-Stream master that generates BIST vector packets. It drives the FIR top-level slave port (S_AXIS_*), i.e. it is the transmitter end of the stream the FIR chain receives.
- Emits PKT_COUNT packets of NUM_OF_SAMPLES beats each, with TLAST on the final beat of every packet.
- Data is either a ramp or an LFSR sequence, so a downstream checker can regenerate it from SEED.

---
 rtl/fir_bist_pkg.sv | 24 ++
 rtl/bist_pattern_gen.sv | 42 ++++
 rtl/axis_bist_src.sv | 143 ++++++++++++++
 tb/tb_axis_bist_src.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_bist_pkg.sv
// Shared definitions for the BIST stream source and its future checker:
// FSM state encoding, pattern mode constants and LFSR tap masks.
package fir_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic MODE_RAMP = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Fibonacci tap mask per supported sample width (bit n set = tap on bit n).
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            32:      return 32'h8020_0003;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Holds the current BIST sample and advances it on step as a ramp or a
// Fibonacci LFSR (shift left, feedback into bit 0). Mode is captured on load.
module bist_pattern_gen
    import fir_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] sample
);

    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

    logic                  mode_q;
    logic [DATA_WIDTH-1:0] next_sample;

    always_comb begin
        next_sample = sample + DATA_WIDTH'(1);
        if (mode_q == MODE_LFSR) begin
            next_sample = {sample[DATA_WIDTH-2:0], ^(sample & TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_RAMP;
            sample <= '0;
        end else if (load) begin
            mode_q <= mode;
            // An all-zero LFSR state would lock up, so a zero seed becomes 1.
            sample <= (mode == MODE_LFSR && seed == '0) ? DATA_WIDTH'(1) : seed;
        end else if (step) begin
            sample <= next_sample;
        end
    end

endmodule

// File: rtl/axis_bist_src.sv
// AXI4-Stream BIST packet source: PKT_COUNT packets of NUM_OF_SAMPLES beats.
// Define FIR_BIST_GAP_EN to insert GAP_CYCLES idle cycles between packets.
module axis_bist_src
    import fir_bist_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_OF_SAMPLES = 1000,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  MODE,
    input  logic [DATA_WIDTH-1:0] SEED,
    input  logic [15:0]           PKT_COUNT,
    input  logic                  M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    output logic                  BUSY,
    output logic                  DONE,
    output state_e                dbg_state
);

    localparam int            CW       = $clog2(NUM_OF_SAMPLES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OF_SAMPLES - 1);

    if (NUM_OF_SAMPLES < 1 || GAP_CYCLES < 1 ||
        !(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_cfg
        $error("axis_bist_src: illegal parameter set");
    end

    // Handshake: a beat moves on an edge where TVALID && TREADY; while
    // TVALID && !TREADY the registered TDATA/TLAST cannot change and TVALID
    // only falls on the edge that completes a transfer (or on reset).
    state_e          state, state_n;
    logic [CW-1:0]   smp_cnt;
    logic [15:0]     pkt_cnt, pkt_total;
    logic            stop_seen;
    logic            tvalid_q, tlast_q, busy_q, done_q;
    logic            xfer, start_ok, end_of_pkt, last_pkt, stop_now, gap_done;

    assign xfer       = tvalid_q & M_AXIS_TREADY;
    assign start_ok   = START & (state == IDLE || state == fir_bist_pkg::DONE);
    assign end_of_pkt = xfer & tlast_q;
    assign last_pkt   = (pkt_total != 16'd0) && (pkt_cnt == pkt_total - 16'd1);
    assign stop_now   = stop_seen | STOP;

`ifdef FIR_BIST_GAP_EN
    localparam state_e AFTER_PKT = GAP;
    localparam int     GW        = $clog2(GAP_CYCLES + 1);
    logic [GW-1:0]     gap_cnt;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN)  gap_cnt <= '0;
        else if (state != GAP) gap_cnt <= '0;
        else                   gap_cnt <= gap_cnt + GW'(1);
    end

    assign gap_done = (gap_cnt == GW'(GAP_CYCLES - 1));
`else
    localparam state_e AFTER_PKT = SEND;
    assign gap_done = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, fir_bist_pkg::DONE: if (START) state_n = SEND;
            SEND: begin
                if (end_of_pkt) begin
                    state_n = (last_pkt || stop_now) ? fir_bist_pkg::DONE : AFTER_PKT;
                end
            end
            GAP: begin
                if (stop_now)      state_n = fir_bist_pkg::DONE;
                else if (gap_done) state_n = SEND;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) state <= IDLE;
        else                 state <= state_n;
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            smp_cnt   <= '0;
            pkt_cnt   <= '0;
            pkt_total <= '0;
            stop_seen <= 1'b0;
        end else begin
            tvalid_q <= (state_n == SEND);
            busy_q   <= (state_n == SEND) || (state_n == GAP);
            done_q   <= (state_n == fir_bist_pkg::DONE);
            if (start_ok) begin
                smp_cnt   <= '0;
                pkt_cnt   <= '0;
                pkt_total <= PKT_COUNT;
                stop_seen <= 1'b0;
                tlast_q   <= (LAST_IDX == '0);
            end else begin
                if ((state == SEND || state == GAP) && STOP) stop_seen <= 1'b1;
                if (xfer) begin
                    if (tlast_q) begin
                        smp_cnt <= '0;
                        pkt_cnt <= pkt_cnt + 16'd1;
                        tlast_q <= (LAST_IDX == '0);
                    end else begin
                        smp_cnt <= smp_cnt + CW'(1);
                        tlast_q <= (smp_cnt + CW'(1) == LAST_IDX);
                    end
                end
            end
        end
    end

    bist_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .clk    (M_AXIS_ACLK),
        .rst_n  (M_AXIS_ARESETN),
        .load   (start_ok),
        .step   (xfer),
        .mode   (MODE),
        .seed   (SEED),
        .sample (M_AXIS_TDATA)
    );

    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_axis_bist_src.sv
// Bench for axis_bist_src: directed runs with an expected-beat queue drained
// by a monitor that also checks stability while the sink stalls.
module tb_axis_bist_src;
    localparam int DW = 16;
    localparam int NS = 4;
    localparam int GC = 4;
`ifdef FIR_BIST_GAP_EN
    localparam int EXP_GAP = GC;
`else
    localparam int EXP_GAP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, mode = 1'b0;
    logic [DW-1:0] seed = '0;
    logic [15:0]   pkt_count = '0;
    logic          tready = 1'b1;
    logic [DW-1:0] tdata;
    logic          tlast, tvalid, busy, done;
    fir_bist_pkg::state_e dbg_state;

    logic [DW:0] exp_q[$];
    int          xfer_cyc[$];
    int          n_checks = 0, n_fail = 0;
    int          cyc = 0, beats_seen = 0;
    logic        bp_en = 1'b0;
    logic        bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int          bp_idx = 0;
    logic        stall_prev = 1'b0;
    logic [DW:0] held;

    axis_bist_src #(.DATA_WIDTH(DW), .NUM_OF_SAMPLES(NS), .GAP_CYCLES(GC)) dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .START(start), .STOP(stop),
        .MODE(mode), .SEED(seed), .PKT_COUNT(pkt_count), .M_AXIS_TREADY(tready),
        .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast), .M_AXIS_TVALID(tvalid),
        .BUSY(busy), .DONE(done), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // backpressure pattern 1,0,0,1
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            tready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_checks++;
                if (!tvalid || {tlast, tdata} !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: got valid=%b last/data=%h, required valid=1 last/data=%h",
                             tvalid, {tlast, tdata}, held);
                end
            end
            if (tvalid && tready) begin
                logic [DW:0] e;
                xfer_cyc.push_back(cyc);
                beats_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got last/data=%h, required no beat", {tlast, tdata});
                end else begin
                    e = exp_q.pop_front();
                    if ({tlast, tdata} !== e) begin
                        n_fail++;
                        $display("FAIL beat: got last/data=%h, required %h", {tlast, tdata}, e);
                    end
                end
            end
            stall_prev = tvalid && !tready;
            held       = {tlast, tdata};
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_start(input logic [DW-1:0] s, input logic m, input logic [15:0] p);
        seed      = s;
        mode      = m;
        pkt_count = p;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic push_ramp(input logic [DW-1:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({(i % NS) == NS - 1, s + DW'(i)});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        @(negedge clk);
        #1;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_tvalid"}, 32'(tvalid), 32'd0);
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats_seen < target && n < 300) begin
            tick();
            n++;
        end
        check("wait_beats_reached", 32'(beats_seen >= target), 32'd1);
    endtask

    initial begin
        int base;
        // reset state
        repeat (3) tick();
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // ramp with wrap, two packets
        xfer_cyc.delete();
        exp_q.push_back(17'h0_FFFE); exp_q.push_back(17'h0_FFFF);
        exp_q.push_back(17'h0_0000); exp_q.push_back(17'h1_0001);
        exp_q.push_back(17'h0_0002); exp_q.push_back(17'h0_0003);
        exp_q.push_back(17'h0_0004); exp_q.push_back(17'h1_0005);
        do_start(16'hFFFE, 1'b0, 16'd2);
        check("first_beat_tvalid", 32'(tvalid), 32'd1);
        check("first_beat_busy", 32'(busy), 32'd1);
        wait_done("ramp");
        check("ramp_beats", 32'(xfer_cyc.size()), 32'd8);
        if (xfer_cyc.size() == 8)
            check("pkt_gap_cycles", 32'(xfer_cyc[4] - xfer_cyc[3] - 1), 32'(EXP_GAP));

        // LFSR from zero seed
        exp_q.push_back(17'h0_0001); exp_q.push_back(17'h0_0002);
        exp_q.push_back(17'h0_0004); exp_q.push_back(17'h1_0008);
        do_start(16'h0000, 1'b1, 16'd1);
        wait_done("lfsr0");

        // LFSR feedback from MSB; a START mid-run is ignored
        exp_q.push_back(17'h0_8000); exp_q.push_back(17'h0_0001);
        exp_q.push_back(17'h0_0002); exp_q.push_back(17'h1_0004);
        do_start(16'h8000, 1'b1, 16'd1);
        tick();
        seed  = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("lfsr8000");

        // backpressure 1,0,0,1
        base   = beats_seen;
        push_ramp(16'h0100, 8);
        bp_idx = 0;
        bp_en  = 1'b1;
        do_start(16'h0100, 1'b0, 16'd2);
        wait_done("backpressure");
        bp_en  = 1'b0;
        tready = 1'b1;
        check("bp_beats", 32'(beats_seen - base), 32'd8);

        // free-running, STOP inside packet 3
        base = beats_seen;
        push_ramp(16'h0010, 12);
        do_start(16'h0010, 1'b0, 16'd0);
        wait_beats(base + 9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("stop");
        repeat (5) tick();
        check("stop_no_more_valid", 32'(tvalid), 32'd0);
        check("stop_done_held", 32'(done), 32'd1);
        check("stop_beats", 32'(beats_seen - base), 32'd12);

        // reset mid-packet, then restart from seed
        base = beats_seen;
        push_ramp(16'h0500, 4);
        do_start(16'h0500, 1'b0, 16'd1);
        wait_beats(base + 2);
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", 32'(tvalid), 32'd0);
        check("midrst_tlast", 32'(tlast), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push_ramp(16'h0500, 4);
        do_start(16'h0500, 1'b0, 16'd1);
        wait_done("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
